id_ex_alu_issue: RTL and testbench

- ID→EX boundary block of the 5-stage MIPS32 pipeline.
- Decodes ALUOp/funct into the 4-bit ALU control code consumed by the EX-stage ALU.
- Selects and registers the ALU operands and the destination register.
- Detects load-use hazards and inserts a bubble, with stall and flush handling, so the ALU sees one cleanly registered operation per cycle.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_ctrl_decode.sv | 32 +++
 rtl/id_ex_alu_issue.sv | 94 +++++++++
 tb/tb_id_ex_alu_issue.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings for the ID/EX boundary: ALUOp values, R-type funct
// codes and the 4-bit control codes driven to the EX-stage ALU.
package alu_pkg;

  localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
  localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
  localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
  localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
  localparam logic [3:0] ALU_CTRL_SLT = 4'b0111;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct to ALU control decode; the only place the
// ALU code map lives. Undecodable combinations fall back to add and flag illegal.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = ALU_CTRL_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_MEM: ctrl = ALU_CTRL_ADD;
      ALUOP_BR:  ctrl = ALU_CTRL_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: ctrl = ALU_CTRL_ADD;
          FUNCT_SUB: ctrl = ALU_CTRL_SUB;
          FUNCT_AND: ctrl = ALU_CTRL_AND;
          FUNCT_OR:  ctrl = ALU_CTRL_OR;
          FUNCT_SLT: ctrl = ALU_CTRL_SLT;
          default:   illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID->EX pipeline register for the ALU path: decode, operand/destination
// select, load-use hazard detection and bubble/stall/flush handling.
module id_ex_alu_issue
  import alu_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [1:0]    id_alu_op,
  input  logic [5:0]    id_funct,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_alu_src,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_reg_dst,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          flush,
  input  logic          ex_stall,
  output logic          ex_valid,
  output logic [3:0]    ex_alu_ctrl,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_rt_data,
  output logic [RW-1:0] ex_dest,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          ex_illegal,
  output logic          load_use_stall
);

  logic [3:0]    dec_ctrl;
  logic          dec_illegal;
  logic          uses_rt;
  logic [RW-1:0] dest_sel;
  logic          kill;

  alu_ctrl_decode u_dec (
    .alu_op  (id_alu_op),
    .funct   (id_funct),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign uses_rt  = (id_alu_op == ALUOP_RTYPE) | ~id_alu_src | id_mem_write;
  assign dest_sel = id_reg_dst ? id_rd : id_rt;

  // $0 is never a real producer, so a load into it cannot create a hazard
  assign load_use_stall = id_valid & ex_valid & ex_mem_read & (ex_dest != '0) &
                          ((ex_dest == id_rs) | (uses_rt & (ex_dest == id_rt)));

  // A load-use bubble only lands when EX is moving; under ex_stall EX just holds
  assign kill = reset | flush | (~ex_stall & load_use_stall);

  // ID -> EX register
  always_ff @(posedge clk) begin
    if (kill) begin
      ex_valid      <= 1'b0;
      ex_alu_ctrl   <= 4'b0000;
      ex_a          <= '0;
      ex_b          <= '0;
      ex_rt_data    <= '0;
      ex_dest       <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_illegal    <= 1'b0;
    end else if (!ex_stall) begin
      ex_valid      <= id_valid;
      ex_alu_ctrl   <= id_valid ? dec_ctrl : 4'b0000;
      ex_a          <= id_rs_data;
      ex_b          <= id_alu_src ? id_imm : id_rt_data;
      ex_rt_data    <= id_rt_data;
      ex_dest       <= dest_sel;
      ex_reg_write  <= id_valid & id_reg_write & ~dec_illegal;
      ex_mem_read   <= id_valid & id_mem_read;
      ex_mem_write  <= id_valid & id_mem_write & ~dec_illegal;
      ex_mem_to_reg <= id_valid & id_mem_to_reg;
      ex_illegal    <= id_valid & dec_illegal;
    end
  end

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed bench for id_ex_alu_issue: table of decode/operand vectors plus
// hand-written load-use, flush/stall and reset sequences.
module tb_id_ex_alu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_alu_src;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        flush, ex_stall;
  logic        ex_valid;
  logic [3:0]  ex_alu_ctrl;
  logic [31:0] ex_a, ex_b, ex_rt_data;
  logic [4:0]  ex_dest;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal;
  logic        load_use_stall;

  int checks = 0;
  int errors = 0;

  id_ex_alu_issue #(.DW(32), .RW(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_funct(id_funct), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_alu_src(id_alu_src), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .flush(flush), .ex_stall(ex_stall),
    .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl), .ex_a(ex_a), .ex_b(ex_b),
    .ex_rt_data(ex_rt_data), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_illegal(ex_illegal),
    .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        alu_src;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rt, rd;
    logic        reg_dst, reg_write, mem_write;
    logic [3:0]  e_ctrl;
    logic        e_illegal;
    logic [31:0] e_b;
    logic [4:0]  e_dest;
    logic        e_reg_write, e_mem_write;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_id();
    id_valid = 0; id_alu_op = 2'b00; id_funct = 6'd0; id_rs_data = 0;
    id_rt_data = 0; id_imm = 0; id_alu_src = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_reg_dst = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    id_mem_to_reg = 0;
  endtask

  task automatic drive_lw(input logic [4:0] rt);
    idle_id();
    id_valid = 1; id_alu_op = 2'b00; id_alu_src = 1; id_rs = 5'd1; id_rt = rt;
    id_rs_data = 32'h1000; id_imm = 32'h8; id_reg_write = 1; id_mem_read = 1;
    id_mem_to_reg = 1;
  endtask

  task automatic drive_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    idle_id();
    id_valid = 1; id_alu_op = 2'b10; id_funct = 6'b100000; id_rs = rs; id_rt = rt;
    id_rd = rd; id_reg_dst = 1; id_reg_write = 1;
    id_rs_data = 32'h11; id_rt_data = 32'h22;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 32'(ex_valid), 0);
    chk({tag, "_ctrlbits"}, {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal}, 0);
  endtask

  initial begin
    //           op     funct      src rs_data       rt_data       imm           rt  rd  dst rw mw  ctrl    ill b             dest rw mw
    vecs[0] = '{2'b10, 6'b100000, 0, 32'h00000005, 32'h00000003, 32'h0,        5'd2, 5'd3, 1, 1, 0, 4'b0010, 0, 32'h00000003, 5'd3, 1, 0};
    vecs[1] = '{2'b10, 6'b100010, 0, 32'hDEADBEEF, 32'h12345678, 32'h0,        5'd2, 5'd4, 1, 1, 0, 4'b0110, 0, 32'h12345678, 5'd4, 1, 0};
    vecs[2] = '{2'b10, 6'b100100, 0, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0,        5'd2, 5'd8, 1, 1, 0, 4'b0000, 0, 32'h0F0F0F0F, 5'd8, 1, 0};
    vecs[3] = '{2'b10, 6'b100101, 0, 32'h00000001, 32'h80000000, 32'h0,        5'd2, 5'd9, 1, 1, 0, 4'b0001, 0, 32'h80000000, 5'd9, 1, 0};
    vecs[4] = '{2'b10, 6'b101010, 0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0,        5'd2, 5'd31,1, 1, 0, 4'b0111, 0, 32'hFFFFFFFF, 5'd31,1, 0};
    vecs[5] = '{2'b10, 6'b000111, 0, 32'h00000010, 32'h00000020, 32'h0,        5'd2, 5'd10,1, 1, 0, 4'b0010, 1, 32'h00000020, 5'd10,0, 0};
    vecs[6] = '{2'b00, 6'b000000, 1, 32'h00000100, 32'hAAAAAAAA, 32'hFFFFFFFC, 5'd12,5'd13,0, 1, 0, 4'b0010, 0, 32'hFFFFFFFC, 5'd12,1, 0};
    vecs[7] = '{2'b01, 6'b100101, 0, 32'h00000007, 32'h00000007, 32'h00000040, 5'd14,5'd15,0, 0, 0, 4'b0110, 0, 32'h00000007, 5'd14,0, 0};
    vecs[8] = '{2'b11, 6'b100000, 1, 32'h00000001, 32'h00000002, 32'h00000003, 5'd16,5'd17,0, 1, 1, 4'b0010, 1, 32'h00000003, 5'd16,0, 0};
    vecs[9] = '{2'b00, 6'b000000, 1, 32'h00000200, 32'h55555555, 32'h00000010, 5'd18,5'd19,0, 0, 1, 4'b0010, 0, 32'h00000010, 5'd18,0, 1};

    idle_id();
    flush = 0; ex_stall = 0; reset = 1;
    step(); step();
    chk_empty("reset");
    chk("reset_ctrl", 32'(ex_alu_ctrl), 0);
    chk("reset_data", ex_a | ex_b | ex_rt_data | 32'(ex_dest), 0);
    chk("reset_lus", 32'(load_use_stall), 0);
    reset = 0;

    // Table: decode, operand and destination selection, one cycle latency
    for (int i = 0; i < 10; i++) begin
      idle_id();
      id_valid = 1; id_alu_op = vecs[i].alu_op; id_funct = vecs[i].funct;
      id_alu_src = vecs[i].alu_src; id_rs_data = vecs[i].rs_data;
      id_rt_data = vecs[i].rt_data; id_imm = vecs[i].imm; id_rs = 5'd1;
      id_rt = vecs[i].rt; id_rd = vecs[i].rd; id_reg_dst = vecs[i].reg_dst;
      id_reg_write = vecs[i].reg_write; id_mem_write = vecs[i].mem_write;
      step();
      chk($sformatf("v%0d_valid", i), 32'(ex_valid), 1);
      chk($sformatf("v%0d_ctrl", i), 32'(ex_alu_ctrl), 32'(vecs[i].e_ctrl));
      chk($sformatf("v%0d_illegal", i), 32'(ex_illegal), 32'(vecs[i].e_illegal));
      chk($sformatf("v%0d_a", i), ex_a, vecs[i].rs_data);
      chk($sformatf("v%0d_b", i), ex_b, vecs[i].e_b);
      chk($sformatf("v%0d_rtdata", i), ex_rt_data, vecs[i].rt_data);
      chk($sformatf("v%0d_dest", i), 32'(ex_dest), 32'(vecs[i].e_dest));
      chk($sformatf("v%0d_regwr", i), 32'(ex_reg_write), 32'(vecs[i].e_reg_write));
      chk($sformatf("v%0d_memwr", i), 32'(ex_mem_write), 32'(vecs[i].e_mem_write));
    end

    // Load-use: lw $5 then add $6,$5,$7
    drive_lw(5'd5);
    step();
    chk("lu_lw_memrd", 32'(ex_mem_read), 1);
    drive_add(5'd5, 5'd7, 5'd6);
    #1;
    chk("lu_stall_on", 32'(load_use_stall), 1);
    step();
    chk_empty("lu_bubble");
    chk("lu_stall_off", 32'(load_use_stall), 0);
    step();
    chk("lu_add_valid", 32'(ex_valid), 1);
    chk("lu_add_ctrl", 32'(ex_alu_ctrl), 32'b0010);
    chk("lu_add_dest", 32'(ex_dest), 6);

    // Load-use via rt only (R-type uses rt)
    drive_lw(5'd9);
    step();
    drive_add(5'd3, 5'd9, 5'd4);
    #1;
    chk("lu_rt_stall", 32'(load_use_stall), 1);
    step();
    chk_empty("lu_rt_bubble");

    // lw to $0 never hazards
    drive_lw(5'd0);
    step();
    drive_add(5'd0, 5'd0, 5'd6);
    #1;
    chk("lu_zero_nostall", 32'(load_use_stall), 0);
    step();
    chk("lu_zero_valid", 32'(ex_valid), 1);
    chk("lu_zero_dest", 32'(ex_dest), 6);

    // Load-use raised under ex_stall: EX holds, then exactly one bubble
    drive_lw(5'd5);
    step();
    drive_add(5'd5, 5'd7, 5'd6);
    ex_stall = 1;
    #1;
    chk("lus_es_stall", 32'(load_use_stall), 1);
    step();
    chk("lus_es_hold_rd", 32'(ex_mem_read), 1);
    chk("lus_es_hold_dest", 32'(ex_dest), 5);
    ex_stall = 0;
    #1;
    chk("lus_es_still", 32'(load_use_stall), 1);
    step();
    chk_empty("lus_es_bubble");
    step();
    chk("lus_es_issue", 32'(ex_valid), 1);
    chk("lus_es_issue_dest", 32'(ex_dest), 6);

    // Flush beats ex_stall
    drive_add(5'd2, 5'd3, 5'd4);
    step();
    chk("fl_pre_valid", 32'(ex_valid), 1);
    flush = 1; ex_stall = 1;
    step();
    flush = 0; ex_stall = 0;
    chk_empty("fl_stall");

    // ex_stall alone holds EX bit-identical for 3 cycles
    idle_id();
    id_valid = 1; id_alu_op = 2'b10; id_funct = 6'b101010; id_rs_data = 32'hCAFEF00D;
    id_rt_data = 32'h0BADBEEF; id_rs = 5'd20; id_rt = 5'd21; id_rd = 5'd22;
    id_reg_dst = 1; id_reg_write = 1;
    step();
    drive_add(5'd1, 5'd2, 5'd3);
    id_rs_data = 32'h1; id_rt_data = 32'h2;
    ex_stall = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("hold%0d_valid", c), 32'(ex_valid), 1);
      chk($sformatf("hold%0d_ctrl", c), 32'(ex_alu_ctrl), 32'b0111);
      chk($sformatf("hold%0d_a", c), ex_a, 32'hCAFEF00D);
      chk($sformatf("hold%0d_b", c), ex_b, 32'h0BADBEEF);
      chk($sformatf("hold%0d_dest", c), 32'(ex_dest), 22);
      chk($sformatf("hold%0d_rw", c), 32'(ex_reg_write), 1);
    end
    ex_stall = 0;
    step();
    chk("hold_release_dest", 32'(ex_dest), 3);

    // Reset during a pending load-use stall
    drive_lw(5'd5);
    step();
    drive_add(5'd5, 5'd7, 5'd6);
    #1;
    chk("rst_mid_stall", 32'(load_use_stall), 1);
    reset = 1;
    step();
    chk_empty("rst_mid");
    chk("rst_mid_ctrl", 32'(ex_alu_ctrl), 0);
    chk("rst_mid_data", ex_a | ex_b | ex_rt_data | 32'(ex_dest), 0);
    chk("rst_mid_lus", 32'(load_use_stall), 0);
    reset = 0;
    step();
    chk("rst_after_issue", 32'(ex_valid), 1);
    chk("rst_after_dest", 32'(ex_dest), 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
